// File: rtl/sprite_index_fetch_pkg.sv
// Shared defaults, widths and the animation state type for sprite_index_fetch.
package sprite_pkg;

  localparam int unsigned DEF_SPRITE_W   = 32;
  localparam int unsigned DEF_SPRITE_H   = 16;
  localparam int unsigned DEF_FRAMES     = 4;
  localparam int unsigned DEF_HOLD       = 8;
  localparam logic [3:0]  DEF_TRANSP_IDX = 4'd0;

  localparam int unsigned ROM_AW  = 11;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned PIX_W   = 4;
  localparam int unsigned FRAME_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_ADVANCE
  } anim_state_t;

endpackage

// File: rtl/sprite_index_fetch_vsync_edge_sync.sv
// Two-flop synchroniser for the vsync input plus a one-cycle rising-edge pulse.
module vsync_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  // Synchronise async_in and keep the previous synchronised value for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign pulse = sync & ~sync_d;

endmodule

// File: rtl/sprite_index_fetch.sv
// Sprite palette-index fetch: box test, ROM addressing, 3-cycle aligned output
// pipeline and optional frame animation (enabled by defining SPRITE_ANIM_EN).
module sprite_index_fetch
  import sprite_pkg::*;
#(
  parameter int unsigned SPRITE_W   = DEF_SPRITE_W,
  parameter int unsigned SPRITE_H   = DEF_SPRITE_H,
  parameter int unsigned FRAMES     = DEF_FRAMES,
  parameter int unsigned HOLD       = DEF_HOLD,
  parameter logic [3:0]  TRANSP_IDX = DEF_TRANSP_IDX
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               blank_in,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
  input  logic               enable,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [PIX_W-1:0]   rom_q,
  output logic [PIX_W-1:0]   index,
  output logic               hit,
  output logic               blank_out,
  output logic [FRAME_W-1:0] frame_idx
);

  logic [COORD_W:0]  dx;
  logic [COORD_W:0]  dy;
  logic              in_box;
  logic [ROM_AW-1:0] addr_c;
  logic              inbox_d1, inbox_d2;
  logic              blank_d1, blank_d2;

  // Stage-1 offsets: zero-extended subtraction, so the MSB is the sign and a
  // sprite running past X=1023 never produces a wrapped hit at small DrawX.
  always_comb begin
    dx     = {1'b0, DrawX} - {1'b0, sprite_x};
    dy     = {1'b0, DrawY} - {1'b0, sprite_y};
    in_box = enable && !dx[COORD_W] && !dy[COORD_W] &&
             (32'(dx[COORD_W-1:0]) < SPRITE_W) &&
             (32'(dy[COORD_W-1:0]) < SPRITE_H);
    addr_c = ROM_AW'(frame_idx) * ROM_AW'(SPRITE_W * SPRITE_H) +
             ROM_AW'(dy[COORD_W-1:0]) * ROM_AW'(SPRITE_W) +
             ROM_AW'(dx[COORD_W-1:0]);
  end

  // Register the ROM address and carry box/blank flags alongside the ROM read.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr <= '0;
      inbox_d1 <= 1'b0;
      inbox_d2 <= 1'b0;
      blank_d1 <= 1'b0;
      blank_d2 <= 1'b0;
    end else begin
      rom_addr <= in_box ? addr_c : '0;
      inbox_d1 <= in_box;
      inbox_d2 <= inbox_d1;
      blank_d1 <= blank_in;
      blank_d2 <= blank_d1;
    end
  end

  // Output stage: combine ROM data with the delayed flags, three cycles after DrawX.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      index     <= TRANSP_IDX;
      hit       <= 1'b0;
      blank_out <= 1'b0;
    end else begin
      index     <= inbox_d2 ? rom_q : TRANSP_IDX;
      hit       <= inbox_d2 && (rom_q != TRANSP_IDX) && blank_d2;
      blank_out <= blank_d2;
    end
  end

`ifdef SPRITE_ANIM_EN
  logic               vs_tick;
  anim_state_t        state, state_nxt;
  logic [7:0]         hold_cnt, hold_cnt_nxt;
  logic [FRAME_W-1:0] frame_q, frame_nxt;

  vsync_edge_sync u_vsync (
    .clk      (Clk),
    .rst      (Reset),
    .async_in (frame_clk),
    .pulse    (vs_tick)
  );

  // Animation state, hold counter and current frame registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      frame_q  <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      frame_q  <= frame_nxt;
    end
  end

  // Next-state logic; a low enable overrides everything, including a vs_tick.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    frame_nxt    = frame_q;
    if (!enable) begin
      state_nxt    = ST_IDLE;
      hold_cnt_nxt = '0;
      frame_nxt    = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          hold_cnt_nxt = '0;
          frame_nxt    = '0;
          state_nxt    = ST_HOLD;
        end
        ST_HOLD: begin
          if (vs_tick) begin
            if (hold_cnt == 8'(HOLD - 1)) begin
              hold_cnt_nxt = '0;
              state_nxt    = ST_ADVANCE;
            end else begin
              hold_cnt_nxt = hold_cnt + 8'd1;
            end
          end
        end
        ST_ADVANCE: begin
          frame_nxt = (frame_q == FRAME_W'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
          state_nxt = ST_HOLD;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign frame_idx = frame_q;
`else
  localparam int unsigned anim_cfg_unused = HOLD + FRAMES;
  logic unused_frame_clk;

  assign unused_frame_clk = frame_clk;
  assign frame_idx        = '0;
`endif

endmodule

// File: tb/tb_sprite_index_fetch.sv
// Directed self-checking bench for sprite_index_fetch (animation checks when SPRITE_ANIM_EN is defined).
module tb_sprite_index_fetch;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [9:0] DrawX, DrawY;
  logic       blank_in;
  logic [9:0] sprite_x, sprite_y;
  logic       enable;
  logic [10:0] rom_addr;
  logic [3:0] rom_q;
  logic [3:0] index;
  logic       hit;
  logic       blank_out;
  logic [1:0] frame_idx;

  int errors = 0;
  int checks = 0;

  sprite_index_fetch #(
    .SPRITE_W   (32),
    .SPRITE_H   (16),
    .FRAMES     (4),
    .HOLD       (8),
    .TRANSP_IDX (4'd0)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .blank_in  (blank_in),
    .sprite_x  (sprite_x),
    .sprite_y  (sprite_y),
    .enable    (enable),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .index     (index),
    .hit       (hit),
    .blank_out (blank_out),
    .frame_idx (frame_idx)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one pixel (held steady) and advance to the next falling edge.
  task automatic px(input logic [9:0] x, input logic [9:0] y, input logic b, input logic [3:0] q);
    DrawX    = x;
    DrawY    = y;
    blank_in = b;
    rom_q    = q;
    @(negedge Clk);
  endtask

  task automatic vs_pulse();
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; enable = 1'b0; blank_in = 1'b0;
    DrawX = '0; DrawY = '0; sprite_x = '0; sprite_y = '0; rom_q = '0;
    repeat (2) @(negedge Clk);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_index", 32'(index), 0);
    check("rst_hit", 32'(hit), 0);
    check("rst_blank_out", 32'(blank_out), 0);
    check("rst_frame_idx", 32'(frame_idx), 0);

    // Box origin right after reset release: latency of 1 for address, 3 for outputs.
    Reset = 1'b0; sprite_x = 10'd100; sprite_y = 10'd50; enable = 1'b1;
    px(10'd100, 10'd50, 1'b1, 4'd5);
    check("origin_addr", 32'(rom_addr), 0);
    @(negedge Clk);
    check("origin_hit_early", 32'(hit), 0);
    check("origin_index_early", 32'(index), 0);
    @(negedge Clk);
    check("origin_index", 32'(index), 5);
    check("origin_hit", 32'(hit), 1);
    check("origin_blank", 32'(blank_out), 1);

    // Bottom-right corner of the box.
    px(10'd131, 10'd65, 1'b1, 4'd9);
    check("corner_addr", 32'(rom_addr), 511);
    repeat (2) @(negedge Clk);
    check("corner_index", 32'(index), 9);
    check("corner_hit", 32'(hit), 1);

    // One pixel past the right edge.
    px(10'd132, 10'd65, 1'b1, 4'd9);
    check("right_out_addr", 32'(rom_addr), 0);
    repeat (2) @(negedge Clk);
    check("right_out_index", 32'(index), 0);
    check("right_out_hit", 32'(hit), 0);
    check("right_out_blank", 32'(blank_out), 1);

    // Transparent pixel inside the box.
    px(10'd110, 10'd60, 1'b1, 4'd0);
    check("transp_addr", 32'(rom_addr), 330);
    repeat (2) @(negedge Clk);
    check("transp_index", 32'(index), 0);
    check("transp_hit", 32'(hit), 0);

    // Blanked pixel inside the box: index passes, hit suppressed.
    px(10'd110, 10'd60, 1'b0, 4'd7);
    check("blanked_addr", 32'(rom_addr), 330);
    repeat (2) @(negedge Clk);
    check("blanked_index", 32'(index), 7);
    check("blanked_hit", 32'(hit), 0);
    check("blanked_blank", 32'(blank_out), 0);

    // Sprite past X=1023 must not wrap to the left of the screen.
    sprite_x = 10'd1010;
    px(10'd5, 10'd50, 1'b1, 4'd7);
    check("wrap_addr", 32'(rom_addr), 0);
    repeat (2) @(negedge Clk);
    check("wrap_hit", 32'(hit), 0);
    check("wrap_index", 32'(index), 0);
    px(10'd1023, 10'd50, 1'b1, 4'd7);
    check("edge1023_addr", 32'(rom_addr), 13);
    repeat (2) @(negedge Clk);
    check("edge1023_hit", 32'(hit), 1);

    // Vertical boundaries.
    sprite_x = 10'd100;
    px(10'd100, 10'd66, 1'b1, 4'd7);
    check("below_addr", 32'(rom_addr), 0);
    repeat (2) @(negedge Clk);
    check("below_hit", 32'(hit), 0);
    px(10'd100, 10'd49, 1'b1, 4'd7);
    check("above_addr", 32'(rom_addr), 0);
    repeat (2) @(negedge Clk);
    check("above_hit", 32'(hit), 0);

    // Disabled sprite never hits.
    enable = 1'b0;
    px(10'd100, 10'd50, 1'b1, 4'd7);
    check("disabled_addr", 32'(rom_addr), 0);
    repeat (2) @(negedge Clk);
    check("disabled_hit", 32'(hit), 0);
    enable = 1'b1;

    // Reset mid-line clears outputs immediately; valid again 3 cycles after release.
    px(10'd101, 10'd51, 1'b1, 4'd5);
    check("pre_rst_addr", 32'(rom_addr), 33);
    repeat (2) @(negedge Clk);
    check("pre_rst_hit", 32'(hit), 1);
    Reset = 1'b1;
    #1;
    check("midrst_hit", 32'(hit), 0);
    check("midrst_index", 32'(index), 0);
    check("midrst_blank", 32'(blank_out), 0);
    check("midrst_addr", 32'(rom_addr), 0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("post_rst_addr", 32'(rom_addr), 33);
    @(negedge Clk);
    check("post_rst_hit_early", 32'(hit), 0);
    @(negedge Clk);
    check("post_rst_hit", 32'(hit), 1);
    check("post_rst_index", 32'(index), 5);

`ifdef SPRITE_ANIM_EN
    repeat (7) vs_pulse();
    check("anim_7", 32'(frame_idx), 0);
    vs_pulse();
    check("anim_8", 32'(frame_idx), 1);
    px(10'd100, 10'd50, 1'b1, 4'd5);
    check("anim_f1_addr", 32'(rom_addr), 512);
    repeat (8) vs_pulse();
    check("anim_16", 32'(frame_idx), 2);
    repeat (8) vs_pulse();
    check("anim_24", 32'(frame_idx), 3);
    repeat (8) vs_pulse();
    check("anim_32_wrap", 32'(frame_idx), 0);

    // Enable low for exactly the cycle the 8th tick is sampled.
    repeat (7) vs_pulse();
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    enable = 1'b0;
    @(negedge Clk);
    enable = 1'b1;
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    check("en_wins_frame", 32'(frame_idx), 0);
    repeat (7) vs_pulse();
    check("en_wins_cnt_clr", 32'(frame_idx), 0);
    vs_pulse();
    check("en_wins_restart", 32'(frame_idx), 1);
`else
    repeat (8) vs_pulse();
    check("static_frame", 32'(frame_idx), 0);
    px(10'd100, 10'd50, 1'b1, 4'd5);
    check("static_addr", 32'(rom_addr), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
